synapse_weight_loader: RTL and testbench
========================================

// Module: synapse_weight_loader
// PURPOSE
//  Upstream AXI4-Lite write master for the synaptic weight memory. Takes a
//  valid/ready stream of (synapse index, 16-bit weight) items from the host
//  loader/DMA path and turns each item into one AXI4-Lite write. With VERIFY=1
//  it reads each weight back and compares it. Error and progress counters go
//  to the control/status register block.
// PARAMETERS
//  NUM_SYNAPSES    72832     valid index range is 0..NUM_SYNAPSES-1
//  IDX_W           17        in_index width
//  BASE_ADDR       32'h0     byte base address of the weight memory
//  VERIFY          0         1 = read back and compare after each write
//  TIMEOUT_CYCLES  1024      maximum wait for any single AXI handshake (>=2)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      input item valid
//  in_ready       out  1      block can accept an item
//  in_index       in   IDX_W  synapse index
//  in_weight      in   16     weight value
//  in_last        in   1      item is the last of the load
//  clear          in   1      synchronous clear of wr_count, err_count, timeout_flag
//  m_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master: awaddr[31:0] awvalid awready wdata[31:0]
//                             wstrb[3:0] wvalid wready bresp[1:0] bvalid bready araddr[31:0]
//                             arvalid arready rdata[31:0] rresp[1:0] rvalid rready
//  busy           out  1      a transaction is in flight (state is not IDLE)
//  done           out  1      1-cycle pulse when the in_last item retires
//  wr_count       out  32     writes completed successfully (wraps)
//  err_count      out  16     errors counted (saturates at 16'hFFFF)
//  timeout_flag   out  1      sticky; set by any timeout
// BEHAVIOUR
//  Reset: all valids, bready, rready, busy, done and timeout_flag are 0; both
//   counters are 0; state is IDLE. Reset asserted mid-transaction aborts it and
//   drops all valids immediately.
//  One item in flight at a time; all outputs are registered.
//  in_ready = 1 only in IDLE. The item is accepted on in_valid & in_ready.
//  Accept with in_index >= NUM_SYNAPSES: no AXI traffic, err_count+1, and the
//   item retires next cycle; if it carries in_last, done pulses.
//  States and transitions:
//  - IDLE -> WRITE on a valid accept. Cycle after accept: awvalid=wvalid=1,
//    awaddr=BASE_ADDR+{in_index,2'b00} (32-bit, wraps), wdata={16'h0,weight},
//    wstrb=4'hF.
//  - WRITE: awvalid and wvalid drop independently on their own handshakes.
//    awaddr and wdata stay stable until both handshakes complete. The slave may
//    complete AW before W, or both in the same cycle; both orders are legal.
//    -> WRESP once both are done.
//  - WRESP: bready=1. On bvalid: if bresp!=OKAY, err_count+1 and retire.
//    Otherwise, with VERIFY=0, wr_count+1 and retire; with VERIFY=1 -> RADDR.
//  - RADDR: arvalid=1, araddr=awaddr. -> RDATA on arready.
//  - RDATA: rready=1. On rvalid, pass requires rresp==OKAY and rdata[15:0]==weight:
//    pass gives wr_count+1, fail gives err_count+1. Then retire.
//  - Retire: -> IDLE; done=1 for one cycle if the item had in_last.
//  Timeout: the cycle counter resets on entry to WRITE, WRESP, RADDR and RDATA.
//   Reaching TIMEOUT_CYCLES drops all valids/readies, err_count+1,
//   timeout_flag=1, then retire. This deliberate AXI abort is for recovery only.
//  clear takes priority over same-cycle increments. It does not affect a
//   transaction in flight.
// TESTING
//  1 Item idx=5, w=16'h1234, last=1, VERIFY=0, slave OKAY -> awaddr=0x14,
//    wdata=0x00001234; wr_count=1; done pulses once; in_ready back to 1.
//  2 VERIFY=1, slave returns rdata=0x1234 -> wr_count+1; slave returns 0x1235
//    -> err_count+1, wr_count unchanged.
//  3 idx=72832 -> no awvalid, err_count=1, in_ready returns after 1 cycle.
//  4 Slave gives awready 3 cycles before wready -> awaddr/wdata stable until
//    wready; exactly one write lands.
//  5 TIMEOUT_CYCLES=16, bvalid never asserted -> at cycle 16 of WRESP
//    timeout_flag=1, err_count=1, IDLE; clear then zeroes all three.
//  6 rst_n low during WRITE -> awvalid/wvalid 0 asynchronously; after release
//    in_ready=1 and counters are 0.

Source files
------------

// File: rtl/synapse_weight_loader.sv
// AXI4-Lite write master for the synaptic weight memory: one (index, weight) item
// becomes one write, optionally followed by a read-back compare.
//
// state    | meaning
// S_IDLE   | ready for the next item
// S_REJECT | out-of-range index, retire without bus traffic
// S_WRITE  | AW and W channels outstanding
// S_WRESP  | waiting for the write response
// S_RADDR  | read-back address outstanding
// S_RDATA  | waiting for read-back data
module synapse_weight_loader #(
  parameter int          NUM_SYNAPSES   = 72832,
  parameter int          IDX_W          = 17,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          VERIFY         = 0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IDX_W-1:0] in_index_i,
  input  logic [15:0]      in_weight_i,
  input  logic             in_last_i,
  input  logic             clear_i,
  output logic [31:0]      m_axi_awaddr_o,
  output logic             m_axi_awvalid_o,
  input  logic             m_axi_awready_i,
  output logic [31:0]      m_axi_wdata_o,
  output logic [3:0]       m_axi_wstrb_o,
  output logic             m_axi_wvalid_o,
  input  logic             m_axi_wready_i,
  input  logic [1:0]       m_axi_bresp_i,
  input  logic             m_axi_bvalid_i,
  output logic             m_axi_bready_o,
  output logic [31:0]      m_axi_araddr_o,
  output logic             m_axi_arvalid_o,
  input  logic             m_axi_arready_i,
  input  logic [31:0]      m_axi_rdata_i,
  input  logic [1:0]       m_axi_rresp_i,
  input  logic             m_axi_rvalid_i,
  output logic             m_axi_rready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      wr_count_o,
  output logic [15:0]      err_count_o,
  output logic             timeout_flag_o
);

  localparam bit             VERIFY_EN = (VERIFY != 0);
  localparam int             TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0] NUM_L     = NUM_SYNAPSES[IDX_W:0];

  typedef enum logic [2:0] {
    S_IDLE, S_REJECT, S_WRITE, S_WRESP, S_RADDR, S_RDATA
  } state_e;

  state_e        state_q;
  logic [31:0]   addr_q;
  logic [15:0]   weight_q;
  logic          last_q;
  logic [TW-1:0] tmr_q;
  logic          in_ready_q, done_q;
  logic          awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [31:0]   wr_count_q;
  logic [15:0]   err_count_q;
  logic          tflag_q;

  logic accept, bad_idx, aw_hs, w_hs, wr_fin, b_hs, ar_hs, r_hs;
  logic active, tmo, rd_pass, err_inc, wr_inc;
  logic unused_rdata_hi;

  assign unused_rdata_hi = ^m_axi_rdata_i[31:16];

  always_comb begin
    accept  = in_valid_i && in_ready_q;
    bad_idx = {1'b0, in_index_i} >= NUM_L;
    aw_hs   = awvalid_q && m_axi_awready_i;
    w_hs    = wvalid_q && m_axi_wready_i;
    wr_fin  = (state_q == S_WRITE) && (!awvalid_q || aw_hs) && (!wvalid_q || w_hs);
    b_hs    = (state_q == S_WRESP) && bready_q && m_axi_bvalid_i;
    ar_hs   = (state_q == S_RADDR) && arvalid_q && m_axi_arready_i;
    r_hs    = (state_q == S_RDATA) && rready_q && m_axi_rvalid_i;
    active  = (state_q == S_WRITE) || (state_q == S_WRESP) ||
              (state_q == S_RADDR) || (state_q == S_RDATA);
    // A handshake landing on the last allowed cycle wins over the timeout.
    tmo     = active && (tmr_q == '0) && !(wr_fin || b_hs || ar_hs || r_hs);
    rd_pass = (m_axi_rresp_i == 2'b00) && (m_axi_rdata_i[15:0] == weight_q);
    err_inc = (accept && bad_idx) || tmo ||
              (b_hs && (m_axi_bresp_i != 2'b00)) || (r_hs && !rd_pass);
    wr_inc  = (b_hs && (m_axi_bresp_i == 2'b00) && !VERIFY_EN) || (r_hs && rd_pass);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      weight_q   <= '0;
      last_q     <= 1'b0;
      tmr_q      <= '0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= BASE_ADDR + 32'({in_index_i, 2'b00});
            weight_q   <= in_weight_i;
            last_q     <= in_last_i;
            in_ready_q <= 1'b0;
            if (bad_idx) begin
              state_q <= S_REJECT;
            end else begin
              state_q   <= S_WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              tmr_q     <= TMR_LOAD;
            end
          end
        end
        S_REJECT: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
          done_q     <= last_q;
        end
        S_WRITE: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (wr_fin) begin
            state_q  <= S_WRESP;
            bready_q <= 1'b1;
            tmr_q    <= TMR_LOAD;
          end else if (tmo) begin
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= last_q;
          end
        end
        S_WRESP: begin
          if (b_hs && VERIFY_EN && (m_axi_bresp_i == 2'b00)) begin
            bready_q  <= 1'b0;
            state_q   <= S_RADDR;
            arvalid_q <= 1'b1;
            tmr_q     <= TMR_LOAD;
          end else if (b_hs || tmo) begin
            bready_q   <= 1'b0;
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= last_q;
          end
        end
        S_RADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RDATA;
            rready_q  <= 1'b1;
            tmr_q     <= TMR_LOAD;
          end else if (tmo) begin
            arvalid_q  <= 1'b0;
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= last_q;
          end
        end
        S_RDATA: begin
          if (r_hs || tmo) begin
            rready_q   <= 1'b0;
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= last_q;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
          awvalid_q  <= 1'b0;
          wvalid_q   <= 1'b0;
          bready_q   <= 1'b0;
          arvalid_q  <= 1'b0;
          rready_q   <= 1'b0;
        end
      endcase
    end
  end

  // clear wins over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q  <= '0;
      err_count_q <= '0;
      tflag_q     <= 1'b0;
    end else if (clear_i) begin
      wr_count_q  <= '0;
      err_count_q <= '0;
      tflag_q     <= 1'b0;
    end else begin
      if (wr_inc) wr_count_q <= wr_count_q + 32'd1;
      if (err_inc && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
      if (tmo) tflag_q <= 1'b1;
    end
  end

  assign in_ready_o      = in_ready_q;
  assign busy_o          = !in_ready_q;
  assign done_o          = done_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = {16'h0, weight_q};
  assign m_axi_wstrb_o   = 4'hF;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;
  assign wr_count_o      = wr_count_q;
  assign err_count_o     = err_count_q;
  assign timeout_flag_o  = tflag_q;

endmodule

// File: tb/tb_synapse_weight_loader.sv
// Bench for synapse_weight_loader: instance 0 has VERIFY=0, instance 1 has VERIFY=1,
// both with TIMEOUT_CYCLES=16, each driven against its own simple AXI4-Lite slave.
module tb_synapse_weight_loader;
  localparam int N = 72832;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  in_valid, in_ready, in_last, clear;
  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready, busy, done, tflag;
  logic [16:0] in_index [2];
  logic [15:0] in_weight [2];
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2], wr_count [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2], rresp [2];
  logic [15:0] err_count [2];

  int          aw_dly [2], w_dly [2];
  logic [1:0]  b_en;
  logic [1:0]  bresp_k [2], rresp_k [2];
  logic [31:0] rdata_k [2];

  int          aw_wait [2], w_wait [2], aw_hs_cnt [2], w_hs_cnt [2];
  logic [1:0]  aw_got, w_got;
  logic [31:0] last_awaddr [2], last_wdata [2];

  int          done_total [2], bready_cyc [2];

  int          exp_wr [2], exp_err [2], exp_hs [2];
  logic [1:0]  exp_tf;
  logic [31:0] exp_addr [2], exp_wdata [2];
  int          last_busy, last_bready;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign awready[g] = awvalid[g] && (aw_wait[g] >= aw_dly[g]);
    assign wready[g]  = wvalid[g] && (w_wait[g] >= w_dly[g]);
    assign arready[g] = arvalid[g];
    assign bresp[g]   = bresp_k[g];
    assign rresp[g]   = rresp_k[g];
    assign rdata[g]   = rdata_k[g];

    synapse_weight_loader #(.VERIFY(g), .TIMEOUT_CYCLES(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]), .in_index_i(in_index[g]),
      .in_weight_i(in_weight[g]), .in_last_i(in_last[g]), .clear_i(clear[g]),
      .m_axi_awaddr_o(awaddr[g]), .m_axi_awvalid_o(awvalid[g]), .m_axi_awready_i(awready[g]),
      .m_axi_wdata_o(wdata[g]), .m_axi_wstrb_o(wstrb[g]), .m_axi_wvalid_o(wvalid[g]),
      .m_axi_wready_i(wready[g]), .m_axi_bresp_i(bresp[g]), .m_axi_bvalid_i(bvalid[g]),
      .m_axi_bready_o(bready[g]), .m_axi_araddr_o(araddr[g]), .m_axi_arvalid_o(arvalid[g]),
      .m_axi_arready_i(arready[g]), .m_axi_rdata_i(rdata[g]), .m_axi_rresp_i(rresp[g]),
      .m_axi_rvalid_i(rvalid[g]), .m_axi_rready_o(rready[g]), .busy_o(busy[g]),
      .done_o(done[g]), .wr_count_o(wr_count[g]), .err_count_o(err_count[g]),
      .timeout_flag_o(tflag[g])
    );
  end

  // Slave: delayed AW/W ready, B one cycle after both beats (unless disabled), R after AR.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        aw_wait[i] <= 0; w_wait[i] <= 0; aw_hs_cnt[i] <= 0; w_hs_cnt[i] <= 0;
        aw_got[i] <= 1'b0; w_got[i] <= 1'b0; bvalid[i] <= 1'b0; rvalid[i] <= 1'b0;
        last_awaddr[i] <= '0; last_wdata[i] <= '0;
      end else begin
        if (awvalid[i] && awready[i]) begin
          aw_got[i] <= 1'b1; aw_hs_cnt[i] <= aw_hs_cnt[i] + 1; aw_wait[i] <= 0;
          last_awaddr[i] <= awaddr[i];
        end else if (awvalid[i]) aw_wait[i] <= aw_wait[i] + 1;
        if (wvalid[i] && wready[i]) begin
          w_got[i] <= 1'b1; w_hs_cnt[i] <= w_hs_cnt[i] + 1; w_wait[i] <= 0;
          last_wdata[i] <= wdata[i];
        end else if (wvalid[i]) w_wait[i] <= w_wait[i] + 1;
        if (aw_got[i] && w_got[i]) begin
          aw_got[i] <= 1'b0; w_got[i] <= 1'b0;
          if (b_en[i]) bvalid[i] <= 1'b1;
        end
        if (bvalid[i] && bready[i]) bvalid[i] <= 1'b0;
        if (arvalid[i] && arready[i]) rvalid[i] <= 1'b1;
        else if (rvalid[i] && rready[i]) rvalid[i] <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the item/counter model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (awvalid[i] || wvalid[i]) begin
          chk($sformatf("awaddr%0d", i), awaddr[i], exp_addr[i]);
          chk($sformatf("wdata%0d", i), wdata[i], exp_wdata[i]);
          chk($sformatf("wstrb%0d", i), {28'h0, wstrb[i]}, 32'hF);
        end
        if (arvalid[i]) chk($sformatf("araddr%0d", i), araddr[i], exp_addr[i]);
        if (in_ready[i]) begin
          chk($sformatf("idle_quiet%0d", i),
              {26'h0, busy[i], awvalid[i], wvalid[i], arvalid[i], bready[i], rready[i]}, 32'h0);
          if (!clear[i]) begin
            chk($sformatf("wr_count%0d", i), wr_count[i], exp_wr[i]);
            chk($sformatf("err_count%0d", i), {16'h0, err_count[i]}, exp_err[i]);
            chk($sformatf("tflag%0d", i), {31'h0, tflag[i]}, {31'h0, exp_tf[i]});
          end
        end else begin
          chk($sformatf("busy%0d", i), {31'h0, busy[i]}, 32'h1);
        end
        if (done[i]) done_total[i] <= done_total[i] + 1;
        if (bready[i]) bready_cyc[i] <= bready_cyc[i] + 1;
      end
    end
  end

  task automatic err_up(input int d);
    if (exp_err[d] < 65535) exp_err[d]++;
  endtask

  task automatic send(input int d, input logic [16:0] idx, input logic [15:0] w, input logic lst);
    int base_done, base_b, n;
    @(negedge clk);
    base_done = done_total[d];
    base_b    = bready_cyc[d];
    in_index[d]  = idx;
    in_weight[d] = w;
    in_last[d]   = lst;
    in_valid[d]  = 1'b1;
    exp_addr[d]  = {13'h0, idx, 2'b00};
    exp_wdata[d] = {16'h0, w};
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    if (int'(idx) >= N) err_up(d);
    else begin
      exp_hs[d]++;
      if (!b_en[d]) begin exp_tf[d] = 1'b1; err_up(d); end
      else if (bresp_k[d] != 2'b00) err_up(d);
      else if (d == 1) begin
        if (rresp_k[d] == 2'b00 && rdata_k[d][15:0] == w) exp_wr[d]++;
        else err_up(d);
      end else exp_wr[d]++;
    end
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!in_ready[d] && n < 300);
    chk("ready_back", {31'h0, in_ready[d]}, 32'h1);
    chk("done_pulses", done_total[d] - base_done, {31'h0, lst});
    chk("aw_beats", aw_hs_cnt[d], exp_hs[d]);
    chk("w_beats", w_hs_cnt[d], exp_hs[d]);
    last_busy   = n - 1;
    last_bready = bready_cyc[d] - base_b;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 2; i++) begin
      exp_wr[i] = 0; exp_err[i] = 0; exp_hs[i] = 0; exp_tf[i] = 1'b0;
    end
  endtask

  initial begin
    in_valid = '0; in_last = '0; clear = '0; b_en = 2'b11;
    for (int i = 0; i < 2; i++) begin
      in_index[i] = '0; in_weight[i] = '0; aw_dly[i] = 0; w_dly[i] = 0;
      bresp_k[i] = 2'b00; rresp_k[i] = 2'b00; rdata_k[i] = '0;
      exp_addr[i] = '0; exp_wdata[i] = '0; done_total[i] = 0; bready_cyc[i] = 0;
    end
    zero_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", {31'h0, in_ready[i]}, 32'h1);
      chk("rst_valids", {27'h0, awvalid[i], wvalid[i], arvalid[i], bready[i], rready[i]}, 32'h0);
      chk("rst_busy_done", {30'h0, busy[i], done[i]}, 32'h0);
      chk("rst_counts", wr_count[i] | {16'h0, err_count[i]} | {31'h0, tflag[i]}, 32'h0);
    end

    send(0, 17'd5, 16'h1234, 1'b1);
    chk("t1_awaddr", last_awaddr[0], 32'h14);
    chk("t1_wdata", last_wdata[0], 32'h0000_1234);
    chk("t1_wr", wr_count[0], 32'd1);
    chk("t1_busy_cycles", last_busy, 32'd3);

    send(0, 17'd72832, 16'h0055, 1'b1);
    chk("t3_err", {16'h0, err_count[0]}, 32'd1);
    chk("t3_busy_cycles", last_busy, 32'd1);
    chk("t3_no_aw", aw_hs_cnt[0], 32'd1);

    send(0, 17'd72831, 16'hFFFF, 1'b0);
    chk("max_idx_addr", last_awaddr[0], 32'h0004_71FC);
    chk("max_idx_wr", wr_count[0], 32'd2);

    w_dly[0] = 3;
    send(0, 17'd9, 16'hBEEF, 1'b0);
    w_dly[0] = 0;
    chk("t4_wdata", last_wdata[0], 32'h0000_BEEF);
    chk("t4_one_write", aw_hs_cnt[0], 32'd3);
    chk("t4_wr", wr_count[0], 32'd3);

    aw_dly[0] = 2;
    send(0, 17'd12, 16'h0F0F, 1'b0);
    aw_dly[0] = 0;
    chk("w_first_addr", last_awaddr[0], 32'h30);

    bresp_k[0] = 2'b10;
    send(0, 17'd20, 16'h0001, 1'b0);
    bresp_k[0] = 2'b00;
    chk("slverr_err", {16'h0, err_count[0]}, 32'd2);

    b_en[0] = 1'b0;
    send(0, 17'd30, 16'h0002, 1'b1);
    b_en[0] = 1'b1;
    chk("t5_flag", {31'h0, tflag[0]}, 32'h1);
    chk("t5_err", {16'h0, err_count[0]}, 32'd3);
    chk("t5_wresp_cycles", last_bready, 32'd16);
    @(negedge clk);
    clear[0] = 1'b1;
    @(posedge clk);
    #1 clear[0] = 1'b0;
    exp_wr[0] = 0; exp_err[0] = 0; exp_tf[0] = 1'b0;
    @(negedge clk); #1;
    chk("t5_clear", wr_count[0] | {16'h0, err_count[0]} | {31'h0, tflag[0]}, 32'h0);

    rdata_k[1] = 32'h0000_1234;
    send(1, 17'd5, 16'h1234, 1'b0);
    chk("t2_pass_wr", wr_count[1], 32'd1);
    rdata_k[1] = 32'h0000_1235;
    send(1, 17'd6, 16'h1234, 1'b1);
    chk("t2_fail_err", {16'h0, err_count[1]}, 32'd1);
    chk("t2_fail_wr", wr_count[1], 32'd1);
    rdata_k[1] = 32'hABCD_5678;
    send(1, 17'd7, 16'h5678, 1'b0);
    chk("t2_hi_ignored", wr_count[1], 32'd2);
    rresp_k[1] = 2'b10;
    send(1, 17'd8, 16'h5678, 1'b0);
    rresp_k[1] = 2'b00;
    chk("t2_rresp_err", {16'h0, err_count[1]}, 32'd2);

    aw_dly[0] = 50;
    @(negedge clk);
    in_index[0] = 17'd3; in_weight[0] = 16'h3333; in_last[0] = 1'b0; in_valid[0] = 1'b1;
    exp_addr[0] = 32'hC; exp_wdata[0] = 32'h3333;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(negedge clk); #1;
    chk("t6_in_write", {31'h0, awvalid[0]}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", {30'h0, awvalid[0], wvalid[0]}, 32'h0);
    zero_model();
    aw_dly[0] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t6_ready", {30'h0, in_ready}, 32'h3);
    chk("t6_counts", wr_count[0] | {16'h0, err_count[0]} | wr_count[1] | {16'h0, err_count[1]}, 32'h0);
    send(0, 17'd1, 16'hA5A5, 1'b1);
    chk("t6_after_wr", wr_count[0], 32'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
